cond_unit_e: RTL and testbench

- Execute-stage condition unit for the pipelined core, sitting directly upstream of the condition checker.
- Holds the architectural NZCV flag register that feeds the checker and evaluates the instruction's condition field against it.
- Gates the execute-stage control signals with the result and writes new ALU flags only for executed instructions.
- Registers the gated controls into the memory stage and keeps executed/squashed instruction counters for debug.

---
 rtl/cond_unit_e.sv | 128 ++++++++++++
 tb/tb_cond_unit_e.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_e.sv
// Execute-stage condition unit: NZCV flag register, ARM condition
// check, control gating, E->M register and exec/squash counters.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   ValidE, StallE      E-stage occupancy and hold
//   CondE               instruction condition field [31:28]
//   ALUFlags            {N,Z,C,V} from this cycle's ALU
//   FlagWriteE          [1] writes N,Z; [0] writes C,V
//   PCSrcE, RegWriteE,
//   MemWriteE, BranchE  ungated decoder controls
//   CountClr            synchronous clear of both counters
//   Flags               registered {N,Z,C,V}
//   CondExE             condition passed and ValidE
//   BranchTakenE        BranchE & CondExE, combinational to fetch
//   PCSrcM, RegWriteM,
//   MemWriteM           gated controls registered into M
//   ExecCount           executed-instruction count (wraps)
//   SquashCount         condition-failed count (wraps)
module cond_unit_e #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ValidE,
  input  logic               StallE,
  input  logic [3:0]         CondE,
  input  logic [3:0]         ALUFlags,
  input  logic [1:0]         FlagWriteE,
  input  logic               PCSrcE,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               BranchE,
  input  logic               CountClr,
  output logic [3:0]         Flags,
  output logic               CondExE,
  output logic               BranchTakenE,
  output logic               PCSrcM,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic [COUNT_W-1:0] ExecCount,
  output logic [COUNT_W-1:0] SquashCount
);

  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       ge, hi;
  logic       cond_pass;
  logic       pcsrc_g;
  logic       regwr_g;
  logic       memwr_g;
  logic       commit;

  assign Flags = flags_q;
  assign {n, z, c, v} = flags_q;
  assign ge = (n == v);
  assign hi = c & ~z;

  always_comb begin
    cond_pass = 1'b0;
    unique case (CondE)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = hi;
      4'b1001: cond_pass = ~hi;
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~z & ge;
      4'b1101: cond_pass = ~(~z & ge);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
    endcase
  end

  assign CondExE      = cond_pass & ValidE;
  assign BranchTakenE = BranchE & CondExE;
  assign pcsrc_g      = PCSrcE & CondExE;
  assign regwr_g      = RegWriteE & CondExE;
  assign memwr_g      = MemWriteE & CondExE;

  // Only an unstalled, executed instruction may touch the flags.
  assign commit = ~StallE & CondExE;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      PCSrcM      <= 1'b0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ExecCount   <= '0;
      SquashCount <= '0;
    end else begin
      if (commit && FlagWriteE[1])
        flags_q[3:2] <= ALUFlags[3:2];
      if (commit && FlagWriteE[0])
        flags_q[1:0] <= ALUFlags[1:0];

      // A stall injects a bubble into M; E re-evaluates next cycle.
      if (StallE) begin
        PCSrcM    <= 1'b0;
        RegWriteM <= 1'b0;
        MemWriteM <= 1'b0;
      end else begin
        PCSrcM    <= pcsrc_g;
        RegWriteM <= regwr_g;
        MemWriteM <= memwr_g;
      end

      // Clear beats both the stall-hold and a same-cycle increment.
      if (CountClr) begin
        ExecCount   <= '0;
        SquashCount <= '0;
      end else if (!StallE && ValidE) begin
        if (CondExE)
          ExecCount <= ExecCount + 1'b1;
        else
          SquashCount <= SquashCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit_e.sv
// Scoreboard bench for cond_unit_e (COUNT_W=4 so wrap is reachable).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_cond_unit_e;

  logic       clk = 1'b0;
  logic       reset;
  logic       ValidE;
  logic       StallE;
  logic [3:0] CondE;
  logic [3:0] ALUFlags;
  logic [1:0] FlagWriteE;
  logic       PCSrcE;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       BranchE;
  logic       CountClr;
  logic [3:0] Flags;
  logic       CondExE;
  logic       BranchTakenE;
  logic       PCSrcM;
  logic       RegWriteM;
  logic       MemWriteM;
  logic [3:0] ExecCount;
  logic [3:0] SquashCount;

  cond_unit_e #(.COUNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .ValidE(ValidE),
    .StallE(StallE),
    .CondE(CondE),
    .ALUFlags(ALUFlags),
    .FlagWriteE(FlagWriteE),
    .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE),
    .BranchE(BranchE),
    .CountClr(CountClr),
    .Flags(Flags),
    .CondExE(CondExE),
    .BranchTakenE(BranchTakenE),
    .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM),
    .ExecCount(ExecCount),
    .SquashCount(SquashCount)
  );

  always #5 clk = ~clk;

  // {CondExE, BranchTakenE, Flags, PCSrcM, RegWriteM, MemWriteM,
  //  ExecCount, SquashCount}
  logic [16:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [3:0] e_flags = '0;
  logic [2:0] e_m = '0;
  logic [3:0] e_exec = '0;
  logic [3:0] e_sq = '0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {CondExE, BranchTakenE, Flags,
            PCSrcM, RegWriteM, MemWriteM,
            ExecCount, SquashCount};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ce=%b bt=%b f=%b m=%b ex=%0d sq=%0d want ce=%b bt=%b f=%b m=%b ex=%0d sq=%0d",
                 nm, a[16], a[15], a[14:11], a[10:8], a[7:4], a[3:0],
                 e[16], e[15], e[14:11], e[10:8], e[7:4], e[3:0]);
      end
    end
  end

  // ARM condition table written straight from the mnemonics.
  function automatic logic ref_cond(input logic [3:0] cc,
                                    input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One E cycle: drive, push expectation, advance expected state.
  task automatic step(input string nm, input logic rst,
                      input logic vld, input logic stl,
                      input logic [3:0] cnd, input logic [3:0] alu,
                      input logic [1:0] fw, input logic [3:0] ctl,
                      input logic clr, input logic ce,
                      input bit chk);
    reset = rst; ValidE = vld; StallE = stl;
    CondE = cnd; ALUFlags = alu; FlagWriteE = fw;
    {PCSrcE, RegWriteE, MemWriteE, BranchE} = ctl;
    CountClr = clr;
    if (chk) begin
      exp_q.push_back({ce, ce & ctl[0], e_flags, e_m, e_exec, e_sq});
      name_q.push_back(nm);
    end
    if (rst) begin
      e_flags = '0; e_m = '0; e_exec = '0; e_sq = '0;
    end else begin
      if (!stl && ce && fw[1]) e_flags[3:2] = alu[3:2];
      if (!stl && ce && fw[0]) e_flags[1:0] = alu[1:0];
      e_m = stl ? 3'b000 : (ctl[3:1] & {3{ce}});
      if (clr) begin
        e_exec = '0; e_sq = '0;
      end else if (!stl && vld) begin
        if (ce) e_exec = e_exec + 4'd1;
        else    e_sq   = e_sq + 4'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    step("reset", 1, 0, 0, 4'h0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    // Flags=0000: EQ fails after reset.
    step("rst_eq", 0, 1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 0, 0, 1);
    step("fw_al", 0, 1, 0, 4'hE, 4'h4, 2'b11, 4'h0, 0, 1, 1);
    step("dep_eq", 0, 1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 0, 1, 1);
    step("dep_ne", 0, 1, 0, 4'h1, 4'h0, 2'b00, 4'h0, 0, 0, 1);
    // Partial write of C,V only: 0100 -> 0111.
    step("part_wr", 0, 1, 0, 4'hE, 4'hB, 2'b01, 4'h0, 0, 1, 1);
    step("set_0011", 0, 1, 0, 4'hE, 4'h3, 2'b11, 4'h0, 0, 1, 1);
    // EQ with Z=0 must not write.
    step("fail_wr", 0, 1, 0, 4'h0, 4'hF, 2'b11, 4'h0, 0, 0, 1);
    step("set_1000", 0, 1, 0, 4'hE, 4'h8, 2'b11, 4'h0, 0, 1, 1);
    // LT with N=1,V=0 passes; held by stall for two cycles.
    step("stall1", 0, 1, 1, 4'hB, 4'h0, 2'b00, 4'h7, 0, 1, 1);
    step("stall2", 0, 1, 1, 4'hB, 4'h0, 2'b00, 4'h7, 0, 1, 1);
    step("release", 0, 1, 0, 4'hB, 4'h0, 2'b00, 4'h7, 0, 1, 1);
    step("m_out", 0, 0, 0, 4'hE, 4'h0, 2'b00, 4'h0, 0, 0, 1);
    step("stall_clr", 0, 1, 1, 4'hE, 4'h0, 2'b00, 4'h0, 1, 1, 1);
    step("after_clr", 0, 0, 0, 4'hE, 4'h0, 2'b00, 4'h0, 0, 0, 1);

    for (int f = 0; f < 16; f++) begin
      step("sw_set", 0, 1, 0, 4'hE, 4'(f), 2'b11, 4'h0, 0, 1, 1);
      for (int cc = 0; cc < 16; cc++)
        step($sformatf("sw_v1_c%0d_f%0d", cc, f), 0, 1, 0, 4'(cc),
             4'h0, 2'b00, 4'h9, 0, ref_cond(4'(cc), 4'(f)), 1);
    end
    for (int f = 0; f < 16; f++) begin
      step("sw_set0", 0, 1, 0, 4'hE, 4'(f), 2'b11, 4'h0, 0, 1, 1);
      for (int cc = 0; cc < 16; cc++)
        step($sformatf("sw_v0_c%0d_f%0d", cc, f), 0, 0, 0, 4'(cc),
             4'hF, 2'b11, 4'hF, 0, 0, 1);
    end

    step("wrap_clr", 0, 0, 0, 4'hE, 4'h0, 2'b00, 4'h0, 1, 0, 1);
    for (int i = 0; i < 16; i++)
      step("wrap_ex", 0, 1, 0, 4'hE, 4'h0, 2'b00, 4'h0, 0, 1, 1);
    step("wrap_chk", 0, 1, 0, 4'hE, 4'h0, 2'b00, 4'h0, 0, 1, 1);
    step("clr_ex", 0, 1, 0, 4'hE, 4'h0, 2'b00, 4'h0, 1, 1, 1);
    step("clr_chk", 0, 1, 0, 4'hE, 4'h5, 2'b11, 4'h4, 0, 1, 1);
    step("mid_stall", 0, 1, 1, 4'hE, 4'hA, 2'b11, 4'h6, 0, 1, 1);
    step("mid_rst", 1, 1, 0, 4'hE, 4'hF, 2'b11, 4'h7, 0, 1, 1);
    step("post_rst", 0, 0, 0, 4'h0, 4'h0, 2'b00, 4'h0, 0, 0, 1);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
